exec_decode_unit: RTL and testbench

Combined decode, execute and branch-resolution stage of the 16-bit single-issue CPU core. It decodes one instruction word per cycle into register indices, immediates and an 8-bit control vector, and computes the ALU result. It holds the Z/N/V condition flags and resolves conditional branches, calls and returns into a next-PC target, and latches the sticky halt state. Sits between the instruction memory/register file and the data memory/PC logic.

---
 rtl/exec_pkg.sv | 59 +++++
 rtl/exec_decode_unit_if.sv | 36 +++
 rtl/exec_decode_unit_br_cond.sv | 31 +++
 rtl/exec_decode_unit.sv | 182 ++++++++++++++++++
 tb/tb_exec_decode_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exec_pkg
// Brief   : Opcode/condition enums, ctrl bit indices, byte saturating add.
// Rev     : 1.0
// ============================================================================
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_PADDSB = 4'h1,
        OP_SUB    = 4'h2,
        OP_AND    = 4'h3,
        OP_NOR    = 4'h4,
        OP_SLL    = 4'h5,
        OP_SRL    = 4'h6,
        OP_SRA    = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LHB    = 4'hA,
        OP_LLB    = 4'hB,
        OP_B      = 4'hC,
        OP_CALL   = 4'hD,
        OP_RET    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        COND_NE     = 3'd0,
        COND_EQ     = 3'd1,
        COND_GT     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_LE     = 3'd5,
        COND_OV     = 3'd6,
        COND_ALWAYS = 3'd7
    } cond_t;

    localparam int c_ctrl_reg_wr   = 0;
    localparam int c_ctrl_mem_rd   = 1;
    localparam int c_ctrl_mem_wr   = 2;
    localparam int c_ctrl_halt     = 3;
    localparam int c_ctrl_call     = 4;
    localparam int c_ctrl_ret      = 5;
    localparam int c_ctrl_branch   = 6;
    localparam int c_ctrl_mem2reg  = 7;

    // Signed byte add clamped to 0x7F / 0x80.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) begin
            return s[8] ? 8'h80 : 8'h7F;
        end
        return s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_decode_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : exec_decode_unit_if
// Brief   : Instruction/operand inputs and decode/execute outputs bundle.
// Rev     : 1.0
// ============================================================================
interface exec_decode_unit_if;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [7:0]  ctrl;
    logic [15:0] imm;
    logic [15:0] result;
    logic        z;
    logic        n;
    logic        v;
    logic        br_taken;
    logic [15:0] target;
    logic        halted;

    modport slave (
        input  valid, instr, pc, rs_data, rt_data,
        output rd, rs, rt, ctrl, imm, result, z, n, v, br_taken, target, halted
    );

    modport master (
        output valid, instr, pc, rs_data, rt_data,
        input  rd, rs, rt, ctrl, imm, result, z, n, v, br_taken, target, halted
    );
endinterface
`default_nettype wire

// File: rtl/exec_decode_unit_br_cond.sv
`default_nettype none
// ============================================================================
// Module  : br_cond
// Brief   : Evaluates a branch condition code against the Z/N/V flags.
// Rev     : 1.0
// ============================================================================
module br_cond
    import exec_pkg::*;
(
    input  cond_t i_cond,
    input  logic  i_z,
    input  logic  i_n,
    input  logic  i_v,
    output logic  o_taken
);
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_NE:     o_taken = ~i_z;
            COND_EQ:     o_taken = i_z;
            COND_GT:     o_taken = ~i_z & ~i_n;
            COND_LT:     o_taken = i_n;
            COND_GE:     o_taken = i_z | ~i_n;
            COND_LE:     o_taken = i_z | i_n;
            COND_OV:     o_taken = i_v;
            COND_ALWAYS: o_taken = 1'b1;
            default:     o_taken = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/exec_decode_unit.sv
`default_nettype none
// ============================================================================
// Module  : exec_decode_unit
// Brief   : Decode/execute/branch stage; SAT_ARITH_EN makes ADD/SUB saturate.
// Rev     : 1.0
// ============================================================================
module exec_decode_unit
    import exec_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    exec_decode_unit_if.slave bus
);
    opcode_t     w_op;
    cond_t       w_cond;
    logic [3:0]  w_rd, w_rs, w_rt;
    logic [7:0]  w_ctrl;
    logic [15:0] w_imm, w_result, w_target, w_pc_inc;
    logic        w_take, w_cond_taken, w_live;
    logic        w_set_znv, w_set_z;
    logic        w_is_sub, w_ovf;
    logic [15:0] w_addend, w_sum, w_arith;
    logic        r_z, r_n, r_v, r_halted;

    assign w_op     = opcode_t'(bus.instr[15:12]);
    assign w_cond   = cond_t'(bus.instr[11:9]);
    assign w_pc_inc = bus.pc + 16'd1;
    assign w_live   = bus.valid & ~r_halted;

    // SUB reuses the adder as rs + ~rt + 1, so one overflow rule covers both.
    assign w_is_sub = (w_op == OP_SUB);
    assign w_addend = w_is_sub ? ~bus.rt_data : bus.rt_data;
    assign w_sum    = bus.rs_data + w_addend + {15'd0, w_is_sub};
    assign w_ovf    = (bus.rs_data[15] == w_addend[15]) && (w_sum[15] != bus.rs_data[15]);

`ifdef SAT_ARITH_EN
    assign w_arith = w_ovf ? (bus.rs_data[15] ? 16'h8000 : 16'h7FFF) : w_sum;
`else
    assign w_arith = w_sum;
`endif

    br_cond u_br_cond (
        .i_cond  (w_cond),
        .i_z     (r_z),
        .i_n     (r_n),
        .i_v     (r_v),
        .o_taken (w_cond_taken)
    );

    always_comb begin
        w_rd      = bus.instr[11:8];
        w_rs      = bus.instr[7:4];
        w_rt      = bus.instr[3:0];
        w_ctrl    = 8'd0;
        w_imm     = 16'd0;
        w_result  = 16'd0;
        w_target  = w_pc_inc;
        w_take    = 1'b0;
        w_set_znv = 1'b0;
        w_set_z   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_result  = w_arith;
                w_set_znv = 1'b1;
            end
            OP_PADDSB: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_result = {sat_add8(bus.rs_data[15:8], bus.rt_data[15:8]),
                            sat_add8(bus.rs_data[7:0],  bus.rt_data[7:0])};
            end
            OP_AND: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_result = bus.rs_data & bus.rt_data;
                w_set_z  = 1'b1;
            end
            OP_NOR: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_result = ~(bus.rs_data | bus.rt_data);
                w_set_z  = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_imm   = {12'd0, bus.instr[3:0]};
                w_set_z = 1'b1;
                if (w_op == OP_SLL)
                    w_result = bus.rs_data << bus.instr[3:0];
                else if (w_op == OP_SRL)
                    w_result = bus.rs_data >> bus.instr[3:0];
                else
                    w_result = 16'($signed(bus.rs_data) >>> bus.instr[3:0]);
            end
            OP_LW: begin
                w_ctrl[c_ctrl_reg_wr]  = 1'b1;
                w_ctrl[c_ctrl_mem_rd]  = 1'b1;
                w_ctrl[c_ctrl_mem2reg] = 1'b1;
                w_imm    = {{12{bus.instr[3]}}, bus.instr[3:0]};
                w_result = bus.rs_data + w_imm;
            end
            OP_SW: begin
                // rd names the store-data register, read through the rt port
                w_ctrl[c_ctrl_mem_wr] = 1'b1;
                w_rt     = bus.instr[11:8];
                w_imm    = {{12{bus.instr[3]}}, bus.instr[3:0]};
                w_result = bus.rs_data + w_imm;
            end
            OP_LHB: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_rs     = bus.instr[11:8];
                w_imm    = {{8{bus.instr[7]}}, bus.instr[7:0]};
                w_result = {bus.instr[7:0], bus.rs_data[7:0]};
            end
            OP_LLB: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_imm    = {{8{bus.instr[7]}}, bus.instr[7:0]};
                w_result = w_imm;
            end
            OP_B: begin
                w_ctrl[c_ctrl_branch] = 1'b1;
                w_imm    = {{7{bus.instr[8]}}, bus.instr[8:0]};
                w_target = w_pc_inc + w_imm;
                w_take   = w_cond_taken;
            end
            OP_CALL: begin
                w_ctrl[c_ctrl_reg_wr] = 1'b1;
                w_ctrl[c_ctrl_call]   = 1'b1;
                w_rd     = 4'hF;
                w_imm    = {{4{bus.instr[11]}}, bus.instr[11:0]};
                w_target = w_pc_inc + w_imm;
                w_result = w_pc_inc;
                w_take   = 1'b1;
            end
            OP_RET: begin
                w_ctrl[c_ctrl_ret] = 1'b1;
                w_rs     = 4'hF;
                w_target = bus.rs_data;
                w_take   = 1'b1;
            end
            OP_HLT: begin
                w_ctrl[c_ctrl_halt] = 1'b1;
            end
            default: begin
                w_ctrl = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_live) begin
            if (w_set_znv) begin
                r_z <= (w_result == 16'd0);
                r_n <= w_result[15];
                r_v <= w_ovf;
            end else if (w_set_z) begin
                r_z <= (w_result == 16'd0);
            end
            if (w_op == OP_HLT) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign bus.rd       = w_rd;
    assign bus.rs       = w_rs;
    assign bus.rt       = w_rt;
    assign bus.imm      = w_imm;
    assign bus.result   = w_result;
    assign bus.target   = w_target;
    assign bus.ctrl     = w_live ? w_ctrl : 8'd0;
    assign bus.br_taken = w_live & w_take;
    assign bus.z        = r_z;
    assign bus.n        = r_n;
    assign bus.v        = r_v;
    assign bus.halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_exec_decode_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_exec_decode_unit
// Brief   : Directed and random stimulus against an integer reference model.
// Rev     : 1.0
// ============================================================================
module tb_exec_decode_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    exec_decode_unit_if bus();

    exec_decode_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic m_z = 1'b0, m_n = 1'b0, m_v = 1'b0, m_halted = 1'b0;
    logic e_nz, e_nn, e_nv, e_nh;
    logic [3:0]  e_rd, e_rs, e_rt;
    logic [7:0]  e_ctrl;
    logic [15:0] e_imm, e_res, e_tgt;
    logic        e_taken;
    logic        chk_res, chk_tgt, chk_imm;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clamp8(input int x);
        if (x > 127)  return 8'h7F;
        if (x < -128) return 8'h80;
        return 8'(x);
    endfunction

    function automatic logic [15:0] sx(input int value);
        return 16'(value);
    endfunction

    // Reference: integer arithmetic straight from the instruction set rules.
    task automatic model();
        logic [15:0] ins;
        logic [3:0]  op;
        int          a, b, s, hi, lo;
        logic        ovf, live, ct;
        logic [15:0] pc1;
        ins  = bus.instr;
        op   = ins[15:12];
        a    = int'($signed(bus.rs_data));
        b    = int'($signed(bus.rt_data));
        pc1  = bus.pc + 16'd1;
        live = bus.valid && !m_halted;
        e_rd = ins[11:8]; e_rs = ins[7:4]; e_rt = ins[3:0];
        e_ctrl = 8'h00; e_imm = 16'h0; e_res = 16'h0; e_tgt = 16'h0; e_taken = 1'b0;
        chk_res = 1'b1; chk_tgt = 1'b0; chk_imm = 1'b0;
        e_nz = m_z; e_nn = m_n; e_nv = m_v; e_nh = m_halted;
        case (op)
            4'h0, 4'h2: begin
                s   = (op == 4'h0) ? a + b : a - b;
                ovf = (s > 32767) || (s < -32768);
`ifdef SAT_ARITH_EN
                if (s > 32767)       e_res = 16'h7FFF;
                else if (s < -32768) e_res = 16'h8000;
                else                 e_res = sx(s);
`else
                e_res = sx(s);
`endif
                e_ctrl = 8'h01;
                e_nz = (e_res == 16'h0); e_nn = e_res[15]; e_nv = ovf;
            end
            4'h1: begin
                hi = int'($signed(bus.rs_data[15:8])) + int'($signed(bus.rt_data[15:8]));
                lo = int'($signed(bus.rs_data[7:0]))  + int'($signed(bus.rt_data[7:0]));
                e_res  = {clamp8(hi), clamp8(lo)};
                e_ctrl = 8'h01;
            end
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                case (op)
                    4'h3:    e_res = bus.rs_data & bus.rt_data;
                    4'h4:    e_res = ~(bus.rs_data | bus.rt_data);
                    4'h5:    e_res = sx(a * (1 << ins[3:0]));
                    4'h6:    e_res = sx(int'(bus.rs_data) / (1 << ins[3:0]));
                    default: e_res = sx(a >>> ins[3:0]);
                endcase
                e_ctrl = 8'h01;
                e_nz   = (e_res == 16'h0);
            end
            4'h8, 4'h9: begin
                e_imm   = sx(int'($signed(ins[3:0])));
                e_res   = sx(a + int'($signed(ins[3:0])));
                chk_imm = 1'b1;
                if (op == 4'h8) begin
                    e_ctrl = 8'b1000_0011;
                end else begin
                    e_ctrl = 8'b0000_0100;
                    e_rt   = ins[11:8];
                end
            end
            4'hA: begin
                e_rs   = ins[11:8];
                e_res  = {ins[7:0], bus.rs_data[7:0]};
                e_ctrl = 8'h01;
            end
            4'hB: begin
                e_imm   = sx(int'($signed(ins[7:0])));
                e_res   = e_imm;
                e_ctrl  = 8'h01;
                chk_imm = 1'b1;
            end
            4'hC: begin
                e_imm   = sx(int'($signed(ins[8:0])));
                e_tgt   = sx(int'(bus.pc) + 1 + int'($signed(ins[8:0])));
                e_ctrl  = 8'h40;
                chk_imm = 1'b1; chk_tgt = 1'b1; chk_res = 1'b0;
                case (ins[11:9])
                    3'd0:    ct = !m_z;
                    3'd1:    ct = m_z;
                    3'd2:    ct = !m_z && !m_n;
                    3'd3:    ct = m_n;
                    3'd4:    ct = m_z || !m_n;
                    3'd5:    ct = m_z || m_n;
                    3'd6:    ct = m_v;
                    default: ct = 1'b1;
                endcase
                e_taken = ct;
            end
            4'hD: begin
                e_rd    = 4'hF;
                e_imm   = sx(int'($signed(ins[11:0])));
                e_tgt   = sx(int'(bus.pc) + 1 + int'($signed(ins[11:0])));
                e_res   = pc1;
                e_ctrl  = 8'h11;
                e_taken = 1'b1;
                chk_imm = 1'b1; chk_tgt = 1'b1;
            end
            4'hE: begin
                e_rs    = 4'hF;
                e_tgt   = bus.rs_data;
                e_ctrl  = 8'h20;
                e_taken = 1'b1;
                chk_tgt = 1'b1; chk_res = 1'b0;
            end
            default: begin
                e_ctrl  = 8'h08;
                e_nh    = 1'b1;
                chk_res = 1'b0;
            end
        endcase
        if (!live) begin
            e_ctrl = 8'h00; e_taken = 1'b0;
            e_nz = m_z; e_nn = m_n; e_nv = m_v; e_nh = m_halted;
        end
    endtask

    task automatic step(input logic vld, input logic [15:0] ins, input logic [15:0] pcv,
                        input logic [15:0] rsd, input logic [15:0] rtd);
        bus.valid = vld; bus.instr = ins; bus.pc = pcv; bus.rs_data = rsd; bus.rt_data = rtd;
        #1;
        model();
        check("rd",       16'(bus.rd),       16'(e_rd));
        check("rs",       16'(bus.rs),       16'(e_rs));
        check("rt",       16'(bus.rt),       16'(e_rt));
        check("ctrl",     16'(bus.ctrl),     16'(e_ctrl));
        check("br_taken", 16'(bus.br_taken), 16'(e_taken));
        if (chk_res) check("result", bus.result, e_res);
        if (chk_tgt) check("target", bus.target, e_tgt);
        if (chk_imm) check("imm",    bus.imm,    e_imm);
        @(posedge clk); #1;
        if (!rst_n) begin
            m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_halted = 1'b0;
        end else begin
            m_z = e_nz; m_n = e_nn; m_v = e_nv; m_halted = e_nh;
        end
        check("z",      16'(bus.z),      16'(m_z));
        check("n",      16'(bus.n),      16'(m_n));
        check("v",      16'(bus.v),      16'(m_v));
        check("halted", 16'(bus.halted), 16'(m_halted));
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] ins;
        bus.valid = 1'b0; bus.instr = 16'h0; bus.pc = 16'h0;
        bus.rs_data = 16'h0; bus.rt_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_z",      16'(bus.z),      16'h0);
        check("rst_n",      16'(bus.n),      16'h0);
        check("rst_v",      16'(bus.v),      16'h0);
        check("rst_halted", 16'(bus.halted), 16'h0);
        rst_n = 1'b1;

        // Signed overflow on ADD, then flags feed an OV branch
        step(1'b1, 16'h0123, 16'h0000, 16'h7FFF, 16'h0001);
`ifdef SAT_ARITH_EN
        check("add_sat_n", 16'(bus.n), 16'h0);
`else
        check("add_wrap_n", 16'(bus.n), 16'h1);
`endif
        check("add_ovf_v", 16'(bus.v), 16'h1);
        step(1'b1, 16'hCC03, 16'h0004, 16'h0000, 16'h0000);
        // SUB to zero, then B EQ +5 at 0x0010
        step(1'b1, 16'h2123, 16'h0008, 16'h0005, 16'h0005);
        step(1'b1, 16'hC205, 16'h0010, 16'h0000, 16'h0000);
        step(1'b1, 16'hC005, 16'h0011, 16'h0000, 16'h0000);
        // CALL backwards, RET, PADDSB, LHB, LLB, LW, SW
        step(1'b1, 16'hDFFE, 16'h0020, 16'h0000, 16'h0000);
        step(1'b1, 16'hE000, 16'h0030, 16'h4321, 16'h0000);
        step(1'b1, 16'h1123, 16'h0040, 16'h7F10, 16'h0120);
        step(1'b1, 16'h1123, 16'h0041, 16'h8080, 16'hFF90);
        step(1'b1, 16'hA1AB, 16'h0042, 16'h1234, 16'h0000);
        step(1'b1, 16'hB180, 16'h0043, 16'h0000, 16'h0000);
        step(1'b1, 16'h812F, 16'h0044, 16'h1000, 16'h0000);
        step(1'b1, 16'h9527, 16'h0045, 16'h2000, 16'h5555);
        step(1'b0, 16'h2123, 16'h0046, 16'h0001, 16'h0005);

        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'h0;
            step(($urandom_range(0, 7) != 0), ins, 16'($urandom), pick_operand(), pick_operand());
        end

        // Halt, then everything becomes a bubble until reset
        step(1'b1, 16'hF000, 16'h0100, 16'h0000, 16'h0000);
        step(1'b1, 16'h0123, 16'h0101, 16'h7FFF, 16'h7FFF);
        step(1'b1, 16'hCE00, 16'h0102, 16'h0000, 16'h0000);
        check("halt_sticky", 16'(bus.halted), 16'h1);
        rst_n = 1'b0;
        step(1'b1, 16'h0123, 16'h0103, 16'h7FFF, 16'h7FFF);
        rst_n = 1'b1;
        step(1'b1, 16'h2123, 16'h0104, 16'h8000, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
